st7735_init_sequencer: RTL and testbench
========================================

Name: st7735_init_sequencer

Overview:
- Sequences the ST7735 panel bring-up: hardware reset pulse, post-reset wait, then a table-driven stream of command and data bytes with embedded millisecond delays.
- Reads the init table from an external synchronous ROM and feeds bytes to the SPI byte shifter over a valid/ready handshake.
- Sits between top-level control (start/init_done) and the LCD SPI shifter. It owns the panel reset pin; the shifter owns CS, MOSI and LCD_CLK.

Parameters:
- CLOCK_SPEED_MHZ, 12, SYSTEM_CLK frequency in MHz; one microsecond equals CLOCK_SPEED_MHZ cycles.
- RESET_LOW_US, 10, duration lcd_rst_n is held low, in microseconds.
- RESET_WAIT_MS, 120, wait after reset release before the first ROM fetch, in milliseconds.
- ROM_ADDR_W, 6, init-table address width; table depth is 2^ROM_ADDR_W.

Ports:
- SYSTEM_CLK  in  1  system clock; all state on rising edge.
- reset_delay  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run the sequence; honoured only in IDLE or DONE.
- busy  out  1  high from accepted start until DONE.
- init_done  out  1  high in DONE when an END entry terminated the sequence.
- seq_error  out  1  high in DONE when the table ran out without an END entry.
- lcd_rst_n  out  1  panel reset pin, active low.
- rom_addr  out  ROM_ADDR_W  init-table read address.
- rom_data  in  10  table entry {type[1:0], payload[7:0]}, valid one cycle after rom_addr.
- tx_valid  out  1  byte available for the shifter.
- tx_ready  in  1  shifter accepts the byte when tx_valid and tx_ready are both high on a clock edge.
- tx_data  out  8  byte to transmit.
- tx_dc  out  1  DC level for the byte: 0 = command, 1 = data.

Behaviour:
- Reset values: busy=0, init_done=0, seq_error=0, lcd_rst_n=1, rom_addr=0, tx_valid=0, tx_data=0, tx_dc=0; state IDLE; all counters 0.
- Entry types:
  - 00 = CMD: send payload with dc=0.
  - 01 = DATA: send payload with dc=1.
  - 10 = DLY: wait payload ms; payload 0 = no wait.
  - 11 = END.
- Timebase: a prescaler produces a one-cycle us tick every CLOCK_SPEED_MHZ cycles. A 10-bit counter produces an ms tick every 1000 us ticks. Both are cleared on entry to RST_LOW, RST_WAIT and DELAY, and run only in those states.
- States:
  - IDLE/DONE + start: next edge sets busy=1, init_done=0, seq_error=0, lcd_rst_n=0, rom_addr=0, and enters RST_LOW. start is ignored in all other states.
  - RST_LOW: lcd_rst_n stays low for exactly RESET_LOW_US*CLOCK_SPEED_MHZ cycles, then lcd_rst_n=1 and the state moves to RST_WAIT.
  - RST_WAIT: after RESET_WAIT_MS ms ticks, go to FETCH.
  - FETCH: rom_addr is stable; go to ROMWAIT.
  - ROMWAIT: go to DECODE; rom_data is sampled at the end of this cycle.
  - DECODE, CMD/DATA: register tx_data=payload, tx_dc=type[0], tx_valid=1; go to SEND.
  - DECODE, DLY with payload > 0: go to DELAY.
  - DECODE, DLY with payload = 0: go to ADVANCE.
  - DECODE, END: enter DONE with init_done=1, busy=0.
  - SEND: hold tx_valid, tx_data and tx_dc stable until the handshake. On the handshake edge, tx_valid=0 and go to ADVANCE. There is no timeout.
  - DELAY: after payload ms ticks, go to ADVANCE.
  - ADVANCE, rom_addr < 2^ROM_ADDR_W-1: rom_addr+1, go to FETCH.
  - ADVANCE, rom_addr at maximum (table exhausted without END): enter DONE with seq_error=1, init_done=0, busy=0. rom_addr does not wrap.
- Latency:
  - start edge to lcd_rst_n low: 1 cycle.
  - Handshake edge N to the next tx_valid rise for consecutive CMD/DATA entries: edge N+4 (ADVANCE, FETCH, ROMWAIT, DECODE).
- DONE holds its flags until the next start or reset. A start in DONE reruns the full sequence, including the reset pulse.
- tx_ready is ignored when tx_valid=0. Exactly one handshake occurs per CMD/DATA entry.
- reset_delay asserted mid-operation, including mid-SEND: all outputs take their reset values immediately and asynchronously. lcd_rst_n releases high, tx_valid drops, and no partial state survives.

Test Plan:
- Bench parameters for all scenarios: CLOCK_SPEED_MHZ=2, RESET_LOW_US=3, RESET_WAIT_MS=1, ROM_ADDR_W=3.
- Reset, then toggle tx_ready and rom_data with no start -> all outputs remain at reset values; rom_addr=0; no tx_valid.
- start pulse -> lcd_rst_n low exactly 6 cycles; then high 2000 cycles before the first FETCH; rom_addr=0 and busy=1 throughout.
- ROM {CMD 0x01, DLY 2, CMD 0x11, DATA 0x05, DLY 0, END}, tx_ready tied high -> required response:
  - Handshakes 0x01/dc0, 0x11/dc0, 0x05/dc1, in that order.
  - The 0x11 tx_valid rises ≥4000 cycles after the 0x01 handshake.
  - init_done=1 and busy=0 after END, at rom_addr=5.
- Backpressure: tx_ready low for 10 cycles while tx_valid=1 -> tx_data and tx_dc constant; exactly one handshake when tx_ready rises; next tx_valid rises 4 edges later.
- ROM of 8 CMD entries with no END -> 8 handshakes, then seq_error=1, init_done=0, busy=0, rom_addr=7.
- reset_delay pulsed during SEND at rom_addr=2 -> lcd_rst_n=1 and tx_valid=0 immediately; a subsequent start reruns the reset pulse and fetches from rom_addr=0.

Source files
------------

// File: rtl/st7735_init_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : st7735_init_sequencer                                         |
// | Purpose  : ST7735 panel bring-up. Pulses the panel reset pin, waits for  |
// |            the panel to settle, then walks an external init-table ROM,  |
// |            streaming CMD/DATA bytes to the SPI byte shifter and         |
// |            honouring embedded millisecond delays.                       |
// | Ports    : SYSTEM_CLK, reset_delay (async, active high)                  |
// |            start -> busy / init_done / seq_error      top-level control  |
// |            lcd_rst_n                                   panel reset pin   |
// |            rom_addr -> rom_data (1-cycle sync read)    init-table ROM    |
// |            tx_valid/tx_ready/tx_data/tx_dc             to SPI shifter    |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module st7735_init_sequencer #(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int RESET_LOW_US    = 10,
  parameter int RESET_WAIT_MS   = 120,
  parameter int ROM_ADDR_W      = 6
) (
  input  logic                  SYSTEM_CLK,
  input  logic                  reset_delay,
  input  logic                  start,
  output logic                  busy,
  output logic                  init_done,
  output logic                  seq_error,
  output logic                  lcd_rst_n,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [9:0]            rom_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_dc
);

  localparam int                  c_PRE_W    = $clog2(CLOCK_SPEED_MHZ + 1);
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST = c_PRE_W'(CLOCK_SPEED_MHZ - 1);
  localparam logic [9:0]          c_US_LAST  = 10'd999;
  localparam logic [ROM_ADDR_W-1:0] c_ADDR_MAX = {ROM_ADDR_W{1'b1}};

  // Init-table entry types
  localparam logic [1:0] c_T_CMD  = 2'b00;
  localparam logic [1:0] c_T_DATA = 2'b01;
  localparam logic [1:0] c_T_DLY  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RST_LOW  = 4'd1,
    S_RST_WAIT = 4'd2,
    S_FETCH    = 4'd3,
    S_ROMWAIT  = 4'd4,
    S_DECODE   = 4'd5,
    S_SEND     = 4'd6,
    S_DELAY    = 4'd7,
    S_ADVANCE  = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t               r_state;
  logic [9:0]           r_entry;   // latched table entry, held through DECODE/SEND/DELAY
  logic [c_PRE_W-1:0]   r_pre;     // cycles within the current microsecond
  logic [9:0]           r_us;      // microseconds within the current millisecond
  logic [15:0]          r_tick;    // completed us (RST_LOW) or ms (RST_WAIT/DELAY) units

  logic        w_us_tick;
  logic        w_ms_tick;
  logic        w_timer_run;
  logic        w_unit_tick;
  logic [15:0] w_tick_target;
  logic        w_tick_done;
  logic        w_timer_clr;

  assign w_us_tick = (r_pre == c_PRE_LAST);
  assign w_ms_tick = w_us_tick && (r_us == c_US_LAST);

  // RST_LOW counts microseconds; RST_WAIT and DELAY count milliseconds.
  always_comb begin
    w_timer_run   = 1'b0;
    w_unit_tick   = 1'b0;
    w_tick_target = 16'd0;
    case (r_state)
      S_RST_LOW: begin
        w_timer_run   = 1'b1;
        w_unit_tick   = w_us_tick;
        w_tick_target = 16'(RESET_LOW_US);
      end
      S_RST_WAIT: begin
        w_timer_run   = 1'b1;
        w_unit_tick   = w_ms_tick;
        w_tick_target = 16'(RESET_WAIT_MS);
      end
      S_DELAY: begin
        w_timer_run   = 1'b1;
        w_unit_tick   = w_ms_tick;
        w_tick_target = {8'd0, r_entry[7:0]};
      end
      default: begin
      end
    endcase
  end

  assign w_tick_done = w_unit_tick && ((r_tick + 16'd1) == w_tick_target);
  // Holding the timebase cleared outside the timed states, and on the cycle a
  // timed state finishes, guarantees every timed state starts from zero.
  assign w_timer_clr = !w_timer_run || w_tick_done;

  always_ff @(posedge SYSTEM_CLK or posedge reset_delay) begin
    if (reset_delay) begin
      r_state   <= S_IDLE;
      r_entry   <= '0;
      r_pre     <= '0;
      r_us      <= '0;
      r_tick    <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      seq_error <= 1'b0;
      lcd_rst_n <= 1'b1;
      rom_addr  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      tx_dc     <= 1'b0;
    end else begin
      // Timebase
      if (w_timer_clr) begin
        r_pre  <= '0;
        r_us   <= '0;
        r_tick <= '0;
      end else if (w_us_tick) begin
        r_pre <= '0;
        r_us  <= (r_us == c_US_LAST) ? 10'd0 : r_us + 10'd1;
        if (w_unit_tick) begin
          r_tick <= r_tick + 16'd1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      // Sequencer
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy      <= 1'b1;
            init_done <= 1'b0;
            seq_error <= 1'b0;
            lcd_rst_n <= 1'b0;
            rom_addr  <= '0;
            r_state   <= S_RST_LOW;
          end
        end
        S_RST_LOW: begin
          if (w_tick_done) begin
            lcd_rst_n <= 1'b1;
            r_state   <= S_RST_WAIT;
          end
        end
        S_RST_WAIT: begin
          if (w_tick_done) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_ROMWAIT;
        end
        S_ROMWAIT: begin
          r_entry <= rom_data;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (r_entry[9:8])
            c_T_CMD, c_T_DATA: begin
              tx_data  <= r_entry[7:0];
              tx_dc    <= r_entry[8];
              tx_valid <= 1'b1;
              r_state  <= S_SEND;
            end
            c_T_DLY: begin
              r_state <= (r_entry[7:0] != 8'd0) ? S_DELAY : S_ADVANCE;
            end
            default: begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_DONE;
            end
          endcase
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            r_state  <= S_ADVANCE;
          end
        end
        S_DELAY: begin
          if (w_tick_done) begin
            r_state <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          // Running off the end of the table without an END entry is an error;
          // the address stays at the last entry rather than wrapping.
          if (rom_addr == c_ADDR_MAX) begin
            seq_error <= 1'b1;
            init_done <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            r_state  <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_st7735_init_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_st7735_init_sequencer                                      |
// | Purpose  : Self-checking bench for st7735_init_sequencer. A table-level  |
// |            reference model predicts the handshake stream, the gaps      |
// |            between bytes and the final flags for each ROM image.        |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_st7735_init_sequencer;

  localparam int CLOCK_SPEED_MHZ = 2;
  localparam int RESET_LOW_US    = 3;
  localparam int RESET_WAIT_MS   = 1;
  localparam int ROM_ADDR_W      = 3;

  localparam int c_DEPTH      = 1 << ROM_ADDR_W;
  localparam int c_LOW_CYC    = RESET_LOW_US * CLOCK_SPEED_MHZ;
  localparam int c_MS_CYC     = 1000 * CLOCK_SPEED_MHZ;
  // Reset release to first tx_valid: the wait, then FETCH, ROMWAIT, DECODE.
  localparam int c_FIRST_LEAD = RESET_WAIT_MS * c_MS_CYC + 3;
  localparam logic [16:0] c_RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0, 1'b0};

  logic                  SYSTEM_CLK = 1'b0;
  logic                  reset_delay = 1'b1;
  logic                  start = 1'b0;
  logic                  busy;
  logic                  init_done;
  logic                  seq_error;
  logic                  lcd_rst_n;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [9:0]            rom_data = 10'd0;
  logic                  tx_valid;
  logic                  tx_ready = 1'b0;
  logic [7:0]            tx_data;
  logic                  tx_dc;

  st7735_init_sequencer #(
    .CLOCK_SPEED_MHZ (CLOCK_SPEED_MHZ),
    .RESET_LOW_US    (RESET_LOW_US),
    .RESET_WAIT_MS   (RESET_WAIT_MS),
    .ROM_ADDR_W      (ROM_ADDR_W)
  ) dut (
    .SYSTEM_CLK  (SYSTEM_CLK),
    .reset_delay (reset_delay),
    .start       (start),
    .busy        (busy),
    .init_done   (init_done),
    .seq_error   (seq_error),
    .lcd_rst_n   (lcd_rst_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_dc       (tx_dc)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  logic [16:0] w_outs;
  assign w_outs = {busy, init_done, seq_error, lcd_rst_n, rom_addr, tx_valid, tx_data, tx_dc};

  int total = 0;
  int bad   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous init-table ROM, optionally replaced by noise.
  logic [9:0] rom [c_DEPTH];
  bit rom_noise = 1'b0;
  always @(posedge SYSTEM_CLK) begin
    rom_data <= rom_noise ? 10'($urandom) : rom[rom_addr];
  end

  // Shifter model: 0 = always ready, 1 = random, 2 = stall 11 cycles per byte.
  int ready_mode = 0;
  int stall_cnt  = 0;
  always @(posedge SYSTEM_CLK) begin
    #1;
    if (tx_valid) stall_cnt++;
    else stall_cnt = 0;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = (stall_cnt > 10);
    endcase
  end

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge SYSTEM_CLK) cyc <= cyc + 1;

  int         rise_q[$];
  int         hs_cyc_q[$];
  logic [8:0] hs_val_q[$];
  int         rst_fall_cyc = -1;
  int         rst_rise_cyc = -1;
  int         hold_err = 0;
  int         bringup_err = 0;
  int         idle_err = 0;
  bit         mon_idle = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_rst_n = 1'b1;
  logic [8:0] held = 9'd0;

  always @(negedge SYSTEM_CLK) begin
    if (tx_valid && !prev_valid) begin
      rise_q.push_back(cyc);
      held = {tx_dc, tx_data};
    end else if (tx_valid && ({tx_dc, tx_data} != held)) begin
      hold_err++;
    end
    if (tx_valid && tx_ready) begin
      hs_cyc_q.push_back(cyc + 1);
      hs_val_q.push_back({tx_dc, tx_data});
    end
    if (!lcd_rst_n && prev_rst_n) rst_fall_cyc = cyc;
    if (lcd_rst_n && !prev_rst_n) rst_rise_cyc = cyc;
    if (rst_fall_cyc >= 0 && (cyc - rst_fall_cyc) <= c_LOW_CYC + RESET_WAIT_MS * c_MS_CYC &&
        (busy !== 1'b1 || rom_addr !== '0)) begin
      bringup_err++;
    end
    if (mon_idle && w_outs !== c_RST_VEC) idle_err++;
    prev_valid = tx_valid;
    prev_rst_n = lcd_rst_n;
  end

  task automatic clear_monitor();
    rise_q.delete();
    hs_cyc_q.delete();
    hs_val_q.delete();
    hold_err     = 0;
    bringup_err  = 0;
    rst_fall_cyc = -1;
    rst_rise_cyc = -1;
  endtask

  // Runs one full sequence and compares it with the table-level prediction.
  task automatic run_table(input int mode, input bit stray_start, input string tag);
    logic [8:0] exp_val[$];
    int         exp_lead[$];
    logic [1:0] typ;
    int         pay, acc, budget, s_edge, n;
    bit         exp_done, exp_err;
    int         exp_addr;

    acc      = c_FIRST_LEAD;
    budget   = c_LOW_CYC + 200;
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_addr = c_DEPTH - 1;
    for (int i = 0; i < c_DEPTH; i++) begin
      typ = rom[i][9:8];
      pay = int'(rom[i][7:0]);
      budget += 80;
      if (typ == 2'b00 || typ == 2'b01) begin
        exp_val.push_back({typ[0], rom[i][7:0]});
        exp_lead.push_back(acc);
        budget += acc;
        acc = 4;
      end else if (typ == 2'b10) begin
        acc += 4 + pay * c_MS_CYC;
      end else begin
        exp_done = 1'b1;
        exp_err  = 1'b0;
        exp_addr = i;
        break;
      end
    end
    budget += acc;

    clear_monitor();
    ready_mode = mode;
    @(negedge SYSTEM_CLK);
    start  = 1'b1;
    s_edge = cyc + 1;
    @(negedge SYSTEM_CLK);
    start = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      @(negedge SYSTEM_CLK);
      n++;
      start = (stray_start && (n == 300 || n == 2010)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;

    check_value({tag, "/finished"}, {31'd0, busy}, 32'd0);
    check_value({tag, "/rst_fall"}, rst_fall_cyc, s_edge);
    check_value({tag, "/rst_low_len"}, rst_rise_cyc - rst_fall_cyc, c_LOW_CYC);
    check_value({tag, "/bringup_busy_addr"}, bringup_err, 0);
    check_value({tag, "/hs_count"}, hs_val_q.size(), exp_val.size());
    check_value({tag, "/rise_count"}, rise_q.size(), exp_val.size());
    for (int i = 0; i < exp_val.size() && i < hs_val_q.size() && i < rise_q.size(); i++) begin
      check_value({tag, "/hs_byte"}, {23'd0, hs_val_q[i]}, {23'd0, exp_val[i]});
      if (i == 0) check_value({tag, "/first_lead"}, rise_q[0] - rst_rise_cyc, exp_lead[0]);
      else        check_value({tag, "/gap"}, rise_q[i] - hs_cyc_q[i-1], exp_lead[i]);
    end
    check_value({tag, "/hold_stable"}, hold_err, 0);
    check_value({tag, "/flags"}, {28'd0, init_done, seq_error, busy, tx_valid},
                {28'd0, exp_done, exp_err, 1'b0, 1'b0});
    check_value({tag, "/rom_addr"}, {29'd0, rom_addr}, exp_addr);
  endtask

  initial begin
    int  n;
    bit  dly_used;
    int  r;

    for (int i = 0; i < c_DEPTH; i++) rom[i] = 10'h000;

    // Reset state, then noise on the inputs without a start.
    repeat (3) @(negedge SYSTEM_CLK);
    check_value("reset_outs", w_outs, c_RST_VEC);
    reset_delay = 1'b0;
    rom_noise   = 1'b1;
    ready_mode  = 1;
    mon_idle    = 1'b1;
    repeat (40) @(negedge SYSTEM_CLK);
    mon_idle  = 1'b0;
    rom_noise = 1'b0;
    check_value("idle_quiet", idle_err, 0);
    check_value("idle_outs", w_outs, c_RST_VEC);

    // Reference table with a 2 ms delay, a zero delay and an END.
    rom[0] = {2'b00, 8'h01};
    rom[1] = {2'b10, 8'd2};
    rom[2] = {2'b00, 8'h11};
    rom[3] = {2'b01, 8'h05};
    rom[4] = {2'b10, 8'd0};
    rom[5] = {2'b11, 8'h00};
    rom[6] = {2'b01, 8'hEE};
    rom[7] = {2'b01, 8'hEE};
    run_table(0, 1'b0, "spec_table");

    // Backpressure on every byte; also a rerun from DONE.
    rom[0] = {2'b00, 8'h36};
    rom[1] = {2'b01, 8'hC8};
    rom[2] = {2'b00, 8'h3A};
    rom[3] = {2'b01, 8'h05};
    rom[4] = {2'b11, 8'h00};
    run_table(2, 1'b0, "backpressure");

    // Table exhausted without END.
    for (int i = 0; i < c_DEPTH; i++) rom[i] = {2'b00, 8'(8'hA0 + i)};
    run_table(0, 1'b0, "no_end");

    // Asynchronous reset while the entry at address 2 is waiting in SEND.
    rom[0] = {2'b00, 8'h2A};
    rom[1] = {2'b01, 8'h00};
    rom[2] = {2'b00, 8'h2B};
    rom[3] = {2'b01, 8'h7F};
    rom[4] = {2'b11, 8'h00};
    clear_monitor();
    ready_mode = 2;
    @(negedge SYSTEM_CLK);
    start = 1'b1;
    @(negedge SYSTEM_CLK);
    start = 1'b0;
    n = 0;
    while (!(tx_valid && rom_addr == 3'd2) && n < 5000) begin
      @(negedge SYSTEM_CLK);
      n++;
    end
    check_value("reach_send_addr2", {28'd0, tx_valid, rom_addr}, {28'd0, 1'b1, 3'd2});
    @(negedge SYSTEM_CLK);
    #1 reset_delay = 1'b1;
    #1 check_value("async_reset_outs", w_outs, c_RST_VEC);
    #1 reset_delay = 1'b0;
    run_table(2, 1'b0, "after_reset");

    // Randomized tables with random shifter readiness and ignored extra starts.
    for (int k = 0; k < 4; k++) begin
      dly_used = 1'b0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r = $urandom_range(0, 15);
        if (r < 6)       rom[i] = {2'b00, 8'($urandom)};
        else if (r < 11) rom[i] = {2'b01, 8'($urandom)};
        else if (r < 14) begin
          if (!dly_used && $urandom_range(0, 1) == 1) begin
            rom[i]   = {2'b10, 8'd1};
            dly_used = 1'b1;
          end else begin
            rom[i] = {2'b10, 8'd0};
          end
        end else begin
          rom[i] = {2'b11, 8'($urandom)};
        end
      end
      run_table(1, 1'b1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
